regfile_scrub_sb: RTL and testbench

//  Parametrised multi-read-port integer register file for the RISC-V core, next generation of the 2R1W file.

---
 rtl/regfile_scrub_sb_if.sv | 36 +++
 rtl/regfile_scrub_sb.sv | 95 +++++++++
 tb/tb_regfile_scrub_sb.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scrub_sb_if.sv
// rtl/regfile_scrub_sb_if.sv - decode/writeback bundle for the scrubbed register file
// Purpose: groups the write, issue and read signals of regfile_scrub_sb.
// Signals:
//   wen/waddr/wdata  writeback write
//   iss_en/iss_addr  issue, marks destination pending
//   raddr/rdata      NRD packed read ports (port p at [p*AW +: AW] / [p*XLEN +: XLEN])
//   busy             per-port pending-producer flag
//   ready            scrub complete
// Modports: master = decode/writeback side, slave = register file.
interface regfile_scrub_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) ();
  localparam int AW = $clog2(NREGS);

  logic                wen;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      busy;
  logic                ready;

  modport master (
    output wen, waddr, wdata, iss_en, iss_addr, raddr,
    input  rdata, busy, ready
  );

  modport slave (
    input  wen, waddr, wdata, iss_en, iss_addr, raddr,
    output rdata, busy, ready
  );
endinterface

// File: rtl/regfile_scrub_sb.sv
// rtl/regfile_scrub_sb.sv - multi-read-port register file with scrub sequencer and pending scoreboard
// Purpose: NREGS x XLEN integer register file, NRD combinational read ports, one write port.
//   After reset every register is cleared one per cycle; ready rises when the sweep ends.
//   A per-register pending bit is set on issue and cleared on writeback so decode can stall.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous, active-low reset
//   bus  regfile_scrub_sb_if.slave (write, issue, read ports, busy, ready)
// Config: define REGFILE_BYPASS_EN for write-through forwarding onto matching read ports.
module regfile_scrub_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               rst,
  regfile_scrub_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [0:0]      state;
  logic [AW-1:0]   clr_ptr;
  logic [NREGS-1:0] pend;
  logic            ready_q;
  logic [XLEN-1:0] regs [NREGS];

  logic run;
  logic wr_ok;
  logic iss_ok;

  // An index names a real, writable register: in range and not a hardwired r0.
  function automatic logic is_legal(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run    = (state == ST_RUN);
  assign wr_ok  = run && bus.wen && is_legal(bus.waddr);
  assign iss_ok = run && bus.iss_en && is_legal(bus.iss_addr);

  // Control: scrub sequencer and scoreboard.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      pend    <= '0;
      ready_q <= 1'b0;
    end else if (state == ST_CLEAR) begin
      // Pointer stops on the last index rather than wrapping.
      if (clr_ptr == LAST_IDX) begin
        state   <= ST_RUN;
        ready_q <= 1'b1;
      end else begin
        clr_ptr <= clr_ptr + AW'(1);
      end
    end else begin
      if (wr_ok)  pend[bus.waddr]    <= 1'b0;
      // Issue after writeback so a same-address collision leaves the new producer pending.
      if (iss_ok) pend[bus.iss_addr] <= 1'b1;
    end
  end

  // Storage has no reset of its own; the scrub sweep clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == ST_CLEAR) regs[clr_ptr]   <= '0;
      else if (wr_ok)        regs[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.ready = ready_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          fwd;

    assign ra  = bus.raddr[p*AW +: AW];
    // Gating on ready_q forces zero data and no busy while scrubbing.
    assign hit = ready_q && is_legal(ra);
`ifdef REGFILE_BYPASS_EN
    assign fwd = wr_ok && (bus.waddr == ra);
`else
    assign fwd = 1'b0;
`endif
    assign bus.rdata[p*XLEN +: XLEN] = fwd ? bus.wdata : (hit ? regs[ra] : '0);
    // A forwarded value is already available, so the port is not stalled.
    assign bus.busy[p] = hit && pend[ra] && !fwd;
  end
endmodule

// File: tb/tb_regfile_scrub_sb.sv
// tb/tb_regfile_scrub_sb.sv - directed plus random checks of regfile_scrub_sb against a reference model
module tb_regfile_scrub_sb;
  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int NRD      = 2;
  localparam int ZERO_REG = 1;
  localparam int AW       = $clog2(NREGS);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_scrub_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_scrub_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(ZERO_REG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural contents, pending flags, edges counted since reset.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  int              m_cnt   = 0;
  bit              m_ready = 1'b0;

  function automatic bit legal(input int a);
    return (a < NREGS) && !(ZERO_REG != 0 && a == 0);
  endfunction

  function automatic int rport(input int p);
    return int'(bus.raddr[p*AW +: AW]);
  endfunction

  function automatic bit fwd_hit(input int a);
    return BYP && m_ready && bus.wen && legal(int'(bus.waddr)) && int'(bus.waddr) == a;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int a);
    if (fwd_hit(a)) return bus.wdata;
    if (!m_ready || !legal(a)) return '0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (fwd_hit(a)) return 1'b0;
    return m_ready && legal(a) && m_pend[a];
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ready", {31'b0, bus.ready}, {31'b0, m_ready});
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rdata%0d@x%0d", p, rport(p)), bus.rdata[p*XLEN +: XLEN], exp_rd(rport(p)));
      chk($sformatf("busy%0d@x%0d", p, rport(p)), {31'b0, bus.busy[p]}, {31'b0, exp_busy(rport(p))});
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      m_cnt   = 0;
      m_ready = 1'b0;
      for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
    end else if (!m_ready) begin
      m_regs[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NREGS) m_ready = 1'b1;
    end else begin
      if (bus.wen && legal(int'(bus.waddr))) begin
        m_regs[bus.waddr] = bus.wdata;
        m_pend[bus.waddr] = 1'b0;
      end
      if (bus.iss_en && legal(int'(bus.iss_addr))) m_pend[bus.iss_addr] = 1'b1;
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wen      = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic write(input int a, input logic [XLEN-1:0] d);
    bus.wen   = 1'b1;
    bus.waddr = AW'(a);
    bus.wdata = d;
  endtask

  task automatic issue(input int a);
    bus.iss_en   = 1'b1;
    bus.iss_addr = AW'(a);
  endtask

  // Counts cycles with ready low, bounded so a stuck sequencer cannot hang the run.
  task automatic scrub_wait(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.ready === 1'b1) break;
      n++;
      cycle();
    end
  endtask

  int n;
  int ra;

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    idle();
    bus.raddr = '0;
    rst = 1'b0;
    @(negedge clk);
    cycle();
    cycle();

    // Initial scrub.
    rst = 1'b1;
    scrub_wait(n);
    chk("scrub_len_initial", XLEN'(n), 32'd32);

    // Scrub clears a preloaded register.
    write(5, 32'hDEADBEEF);
    cycle();
    idle();
    set_rd(0, 5);
    #1 chk("x5_preload", bus.rdata[0 +: XLEN], 32'hDEADBEEF);
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    scrub_wait(n);
    chk("scrub_len_pulse", XLEN'(n), 32'd32);
    #1 chk("x5_scrubbed", bus.rdata[0 +: XLEN], 32'h0);
    cycle();

    // Reset in the middle of a scrub restarts the sweep.
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    repeat (10) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    scrub_wait(n);
    chk("scrub_len_restart", XLEN'(n), 32'd32);
    for (int a = 0; a < NREGS; a += 2) begin
      set_rd(0, a);
      set_rd(1, a + 1);
      #1 chk($sformatf("sweep_x%0d", a + 1), bus.rdata[XLEN +: XLEN], 32'h0);
      cycle();
    end

    // Hardwired zero register ignores writes and issues.
    write(0, 32'h1234);
    issue(0);
    set_rd(0, 0);
    set_rd(1, 0);
    cycle();
    idle();
    repeat (3) begin
      #1 chk("x0_data", bus.rdata[0 +: XLEN], 32'h0);
      chk("x0_busy", {31'b0, bus.busy[0]}, 32'h0);
      cycle();
    end

    // Scoreboard set by issue, cleared by writeback.
    issue(7);
    cycle();
    idle();
    set_rd(0, 7);
    #1 chk("x7_busy_set", {31'b0, bus.busy[0]}, 32'h1);
    write(7, 32'hA5A5A5A5);
    cycle();
    idle();
    #1 chk("x7_busy_clr", {31'b0, bus.busy[0]}, 32'h0);
    chk("x7_data", bus.rdata[0 +: XLEN], 32'hA5A5A5A5);
    cycle();

    // Same-cycle issue and writeback: data lands, new producer stays pending.
    issue(9);
    write(9, 32'h11);
    set_rd(0, 9);
    cycle();
    idle();
    #1 chk("x9_data", bus.rdata[0 +: XLEN], 32'h11);
    chk("x9_busy", {31'b0, bus.busy[0]}, 32'h1);
    cycle();
    cycle();
    #1 chk("x9_busy_held", {31'b0, bus.busy[0]}, 32'h1);
    write(9, 32'h22);
    cycle();
    idle();
    #1 chk("x9_busy_done", {31'b0, bus.busy[0]}, 32'h0);
    cycle();

    // Write-through on a matching read port.
    write(3, 32'h55);
    set_rd(1, 3);
    #1 chk("x3_same_cycle", bus.rdata[XLEN +: XLEN], BYP ? 32'h55 : 32'h0);
    cycle();
    idle();
    #1 chk("x3_next_cycle", bus.rdata[XLEN +: XLEN], 32'h55);
    cycle();

    // Randomized traffic, biased toward a few registers so pending bits collide.
    for (int i = 0; i < 600; i++) begin
      bus.wen      = ($urandom % 2) == 0;
      bus.waddr    = AW'(($urandom % 2) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
      bus.wdata    = $urandom;
      bus.iss_en   = ($urandom % 3) == 0;
      bus.iss_addr = AW'(($urandom % 2) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
      for (int p = 0; p < NRD; p++) begin
        ra = ($urandom % 2) ? int'(bus.waddr) : int'($urandom_range(0, 7));
        set_rd(p, ra);
      end
      cycle();
    end
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
